// File: rtl/req_encoder_seq_if.sv
// Handshake bundle for req_encoder_seq: request vector in, one binary index per beat out.
// The master side drives requests and consumer ready; the slave side is the encoder.
interface req_encoder_seq_if #(
  parameter int N = 4,
  parameter int W = 2
);
  logic         req_valid;
  logic         req_ready;
  logic [N-1:0] req;
  logic         enc_valid;
  logic         enc_ready;
  logic [W-1:0] enc_idx;
  logic         enc_last;
  logic         busy;

  modport master (
    output req_valid, req, enc_ready,
    input  req_ready, enc_valid, enc_idx, enc_last, busy
  );

  modport slave (
    input  req_valid, req, enc_ready,
    output req_ready, enc_valid, enc_idx, enc_last, busy
  );
endinterface

// File: rtl/req_encoder_seq.sv
// Sequential multi-hot to binary request encoder: one index per handshake until the vector drains.
// Optional ENC_ROUND_ROBIN_EN: rotating search pointer instead of lowest-index-first priority.
module req_encoder_seq #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic              clk,
  input  logic              rst,
  req_encoder_seq_if.slave  bus
);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t       state, state_nx;
  logic [N-1:0] pend, pend_nx;
  logic [N-1:0] sel_mask;
  logic [W-1:0] base;
  logic [W-1:0] sel;
  logic [W:0]   cnt;
  logic         last;

`ifdef ENC_ROUND_ROBIN_EN
  logic [W-1:0] ptr, ptr_nx;
  assign base = ptr;
`else
  assign base = '0;
`endif

  // Search starts at base and wraps modulo N, so non-power-of-2 N never selects a phantom bit.
  always_comb begin
    int unsigned j;
    logic        found;
    sel   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned off = 0; off < N; off++) begin
      j = 32'(base) + off;
      if (j >= N) j = j - N;
      if (!found && pend[W'(j)]) begin
        found = 1'b1;
        sel   = W'(j);
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cnt = cnt + (W+1)'(pend[W'(i)]);
    end
  end

  always_comb begin
    sel_mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sel_mask[W'(i)] = (W'(i) == sel);
    end
  end

  assign last = (cnt == (W+1)'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pend  <= '0;
`ifdef ENC_ROUND_ROBIN_EN
      ptr   <= '0;
`endif
    end else begin
      state <= state_nx;
      pend  <= pend_nx;
`ifdef ENC_ROUND_ROBIN_EN
      ptr   <= ptr_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    pend_nx  = pend;
`ifdef ENC_ROUND_ROBIN_EN
    ptr_nx   = ptr;
`endif
    unique case (state)
      IDLE: begin
        // An all-zero vector is still accepted, just never served.
        if (bus.req_valid && (bus.req != '0)) begin
          pend_nx  = bus.req;
          state_nx = SERVE;
        end
      end
      SERVE: begin
        if (bus.enc_ready) begin
          pend_nx = pend & ~sel_mask;
`ifdef ENC_ROUND_ROBIN_EN
          ptr_nx  = (sel == W'(N-1)) ? '0 : sel + 1'b1;
`endif
          if (last) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs depend only on registered state, so reset clears them without waiting for clk.
  assign bus.req_ready = (state == IDLE);
  assign bus.enc_valid = (state == SERVE);
  assign bus.enc_idx   = (state == SERVE) ? sel : '0;
  assign bus.enc_last  = (state == SERVE) && last;
  assign bus.busy      = (state == SERVE);

endmodule
